// File: rtl/mips_mem_pkg.sv
// Shared definitions for the data-memory port arbiter: FSM encoding, lane ids,
// latency limits and the latched request payload.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } arb_state_e;

    localparam logic LANE0 = 1'b0;
    localparam logic LANE1 = 1'b1;

    localparam int unsigned DATA_W      = 32;
    localparam int unsigned MEM_LAT_MIN = 1;
    localparam int unsigned MEM_LAT_MAX = 15;
    localparam int unsigned LAT_CNT_W   = 4;

    typedef struct packed {
        logic              we;
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

    // Out-of-range latencies are pinned to the nearest legal value.
    function automatic int unsigned clamp_lat(input int unsigned lat);
        if (lat < MEM_LAT_MIN) return MEM_LAT_MIN;
        if (lat > MEM_LAT_MAX) return MEM_LAT_MAX;
        return lat;
    endfunction

endpackage

// File: rtl/dmem_lat_counter.sv
// Memory-latency down-counter: loadable, saturating decrement, registered zero flag.
module dmem_lat_counter
    import mips_mem_pkg::*;
#(
    parameter int unsigned W = LAT_CNT_W
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q, cnt_d;
    logic         zero_q;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Zero flag tracks the value being written so it is valid in the following cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            zero_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            zero_q <= (cnt_d == '0);
        end
    end

    assign zero_o = zero_q;

endmodule

// File: rtl/dmem_port_arbiter.sv
// Two-lane data-memory arbiter: lane 0 (older instruction) wins ties, one access in
// flight, back-to-back hand-over to the other lane straight out of RESP.
module dmem_port_arbiter
    import mips_mem_pkg::*;
#(
    parameter int unsigned MEM_LAT = 1,
    parameter int unsigned ADDR_W  = 8
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              Req0,
    input  logic              Req1,
    input  logic              We0,
    input  logic              We1,
    input  logic [31:0]       Addr0,
    input  logic [31:0]       Addr1,
    input  logic [31:0]       WData0,
    input  logic [31:0]       WData1,
    output logic              Ack0,
    output logic              Ack1,
    output logic [31:0]       RData0,
    output logic [31:0]       RData1,
    output logic              Stall0,
    output logic              Stall1,
    output logic              MemEn,
    output logic              MemWe,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [31:0]       MemWData,
    input  logic [31:0]       MemRData
);

    localparam int unsigned           LAT      = clamp_lat(MEM_LAT);
    localparam logic [LAT_CNT_W-1:0]  LAT_LOAD = LAT_CNT_W'(LAT - 1);

    arb_state_e  state_q, state_d;
    logic        grant_q, grant_d;
    mem_req_t    req_q, req_d;
    logic        ack0_q, ack0_d, ack1_q, ack1_d;
    logic [31:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic        mem_en_q, mem_en_d, mem_we_q, mem_we_d;

    logic        cnt_load, cnt_dec, cnt_zero;
    logic        launch, launch_lane;
    mem_req_t    lane0_req, lane1_req, pick;
    logic [31:0] resp_data;
    logic        unused_addr_bits;

    assign lane0_req = '{we: We0, addr: Addr0, wdata: WData0};
    assign lane1_req = '{we: We1, addr: Addr1, wdata: WData1};

    dmem_lat_counter #(.W(LAT_CNT_W)) u_lat_cnt (
        .clk_i      (CLK),
        .rst_i      (Reset),
        .load_i     (cnt_load),
        .load_val_i (LAT_LOAD),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    // Next-state, grant and response logic. A lane whose Ack is on the wire is
    // still holding Req this cycle, so it is masked to avoid a duplicate grant.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        req_d       = req_q;
        ack0_d      = 1'b0;
        ack1_d      = 1'b0;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        cnt_load    = 1'b0;
        cnt_dec     = 1'b0;
        launch      = 1'b0;
        launch_lane = LANE0;
        resp_data   = req_q.we ? 32'h0 : MemRData;

        unique case (state_q)
            ST_IDLE: begin
                if (Req0 && !ack0_q) begin
                    launch      = 1'b1;
                    launch_lane = LANE0;
                end else if (Req1 && !ack1_q) begin
                    launch      = 1'b1;
                    launch_lane = LANE1;
                end
            end
            ST_ACCESS, ST_WAIT: begin
                if (cnt_zero) begin
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_WAIT;
                    cnt_dec = 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                if (grant_q == LANE0) begin
                    ack0_d      = 1'b1;
                    rdata0_d    = resp_data;
                    launch      = Req1;
                    launch_lane = LANE1;
                end else begin
                    ack1_d      = 1'b1;
                    rdata1_d    = resp_data;
                    launch      = Req0;
                    launch_lane = LANE0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        pick = (launch_lane == LANE1) ? lane1_req : lane0_req;
        if (launch) begin
            state_d  = ST_ACCESS;
            grant_d  = launch_lane;
            req_d    = pick;
            cnt_load = 1'b1;
            mem_en_d = 1'b1;
            mem_we_d = pick.we;
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q  <= ST_IDLE;
            grant_q  <= LANE0;
            req_q    <= '0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            req_q    <= req_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            mem_en_q <= mem_en_d;
            mem_we_q <= mem_we_d;
        end
    end

    assign Ack0     = ack0_q;
    assign Ack1     = ack1_q;
    assign RData0   = rdata0_q;
    assign RData1   = rdata1_q;
    assign MemEn    = mem_en_q;
    assign MemWe    = mem_we_q;
    assign MemAddr  = req_q.addr[ADDR_W+1:2];
    assign MemWData = req_q.wdata;
    assign Stall0   = Req0 & ~ack0_q;
    assign Stall1   = Req1 & ~ack1_q;

    // Byte-offset and high address bits are not part of the word address.
    assign unused_addr_bits = ^req_q.addr;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: two instances (MEM_LAT=1 and 3) behind simple
// latency-pipelined memories, scoreboard of expected acks and per-scenario timing checks.
module tb_dmem_port_arbiter;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        Reset;
    logic        Req0, Req1, We0, We1;
    logic [31:0] Addr0, Addr1, WData0, WData1;

    logic        a_Ack0, a_Ack1, a_Stall0, a_Stall1, a_MemEn, a_MemWe;
    logic [31:0] a_RData0, a_RData1, a_MemWData, a_MemRData;
    logic [7:0]  a_MemAddr;
    logic        b_Ack0, b_Ack1, b_Stall0, b_Stall1, b_MemEn, b_MemWe;
    logic [31:0] b_RData0, b_RData1, b_MemWData, b_MemRData;
    logic [7:0]  b_MemAddr;

    dmem_port_arbiter #(.MEM_LAT(1), .ADDR_W(8)) dut_a (
        .CLK(CLK), .Reset(Reset),
        .Req0(Req0), .Req1(Req1), .We0(We0), .We1(We1),
        .Addr0(Addr0), .Addr1(Addr1), .WData0(WData0), .WData1(WData1),
        .Ack0(a_Ack0), .Ack1(a_Ack1), .RData0(a_RData0), .RData1(a_RData1),
        .Stall0(a_Stall0), .Stall1(a_Stall1),
        .MemEn(a_MemEn), .MemWe(a_MemWe), .MemAddr(a_MemAddr),
        .MemWData(a_MemWData), .MemRData(a_MemRData)
    );

    dmem_port_arbiter #(.MEM_LAT(3), .ADDR_W(8)) dut_b (
        .CLK(CLK), .Reset(Reset),
        .Req0(Req0), .Req1(Req1), .We0(We0), .We1(We1),
        .Addr0(Addr0), .Addr1(Addr1), .WData0(WData0), .WData1(WData1),
        .Ack0(b_Ack0), .Ack1(b_Ack1), .RData0(b_RData0), .RData1(b_RData1),
        .Stall0(b_Stall0), .Stall1(b_Stall1),
        .MemEn(b_MemEn), .MemWe(b_MemWe), .MemAddr(b_MemAddr),
        .MemWData(b_MemWData), .MemRData(b_MemRData)
    );

    // Memory models: read data emerges MEM_LAT cycles after the strobe, poison otherwise.
    logic        pl_we, pl_sel;
    logic [7:0]  pl_addr;
    logic [31:0] pl_data;
    logic [31:0] mem_a [256];
    logic [31:0] mem_b [256];
    logic [31:0] a_p0, b_p0, b_p1, b_p2;

    always @(posedge CLK) begin
        if (pl_we && !pl_sel)          mem_a[pl_addr]   <= pl_data;
        else if (a_MemEn && a_MemWe)   mem_a[a_MemAddr] <= a_MemWData;
        a_p0 <= a_MemEn ? mem_a[a_MemAddr] : 32'hBAD0_BAD0;
    end
    assign a_MemRData = a_p0;

    always @(posedge CLK) begin
        if (pl_we && pl_sel)           mem_b[pl_addr]   <= pl_data;
        else if (b_MemEn && b_MemWe)   mem_b[b_MemAddr] <= b_MemWData;
        b_p0 <= b_MemEn ? mem_b[b_MemAddr] : 32'hBAD0_BAD0;
        b_p1 <= b_p0;
        b_p2 <= b_p1;
    end
    assign b_MemRData = b_p2;

    // Observed instance
    logic        sel;
    logic        o_ack0, o_ack1, o_stall0, o_stall1, o_en;
    logic [7:0]  o_addr;
    logic [31:0] o_rd0, o_rd1;
    assign o_ack0   = sel ? b_Ack0   : a_Ack0;
    assign o_ack1   = sel ? b_Ack1   : a_Ack1;
    assign o_stall0 = sel ? b_Stall0 : a_Stall0;
    assign o_stall1 = sel ? b_Stall1 : a_Stall1;
    assign o_en     = sel ? b_MemEn  : a_MemEn;
    assign o_addr   = sel ? b_MemAddr : a_MemAddr;
    assign o_rd0    = sel ? b_RData0 : a_RData0;
    assign o_rd1    = sel ? b_RData1 : a_RData1;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic        lane;
        logic [31:0] data;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic mon_en = 1'b0;

    // Scoreboard: every ack of the observed instance must match the oldest expectation.
    always @(negedge CLK) begin : sb_monitor
        exp_t        e;
        logic [31:0] got;
        if (mon_en && (o_ack0 || o_ack1)) begin
            if (sbq.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL sb_unexpected_ack: got ack0=%0b ack1=%0b at cycle %0d, expected no ack",
                         o_ack0, o_ack1, cyc);
            end else begin
                e = sbq.pop_front();
                n_cmp++;
                if ({o_ack1, o_ack0} !== (e.lane ? 2'b10 : 2'b01)) begin
                    n_bad++;
                    $display("FAIL sb_lane: got {ack1,ack0}=%b expected lane %0d at cycle %0d",
                             {o_ack1, o_ack0}, e.lane, cyc);
                end
                got = e.lane ? o_rd1 : o_rd0;
                n_cmp++;
                if (got !== e.data) begin
                    n_bad++;
                    $display("FAIL sb_rdata: lane %0d got %h expected %h at cycle %0d",
                             e.lane, got, e.data, cyc);
                end
            end
        end
    end

    task automatic do_reset(input logic s);
        mon_en = 1'b0;
        @(negedge CLK);
        Reset = 1'b1;
        Req0  = 1'b0;
        Req1  = 1'b0;
        sel   = s;
        @(negedge CLK);
        Reset  = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic preload(input logic s, input logic [7:0] a, input logic [31:0] d);
        @(negedge CLK);
        pl_we = 1'b1; pl_sel = s; pl_addr = a; pl_data = d;
        @(negedge CLK);
        pl_we = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge CLK);
        Req0 = 1'b1;
        Req1 = 1'b1;
        @(negedge CLK);
        n_cmp++;
        if ({a_Ack0, a_Ack1, a_MemEn, a_MemWe} !== 4'b0) begin
            n_bad++;
            $display("FAIL reset_a_ctrl: got %b expected 0000", {a_Ack0, a_Ack1, a_MemEn, a_MemWe});
        end
        n_cmp++;
        if ({a_MemAddr, a_MemWData} !== 40'b0) begin
            n_bad++;
            $display("FAIL reset_a_bus: got addr=%h wdata=%h expected 0", a_MemAddr, a_MemWData);
        end
        n_cmp++;
        if ({a_RData0, a_RData1} !== 64'b0) begin
            n_bad++;
            $display("FAIL reset_a_rdata: got %h %h expected 0", a_RData0, a_RData1);
        end
        n_cmp++;
        if ({b_Ack0, b_Ack1, b_MemEn, b_MemWe} !== 4'b0) begin
            n_bad++;
            $display("FAIL reset_b_ctrl: got %b expected 0000", {b_Ack0, b_Ack1, b_MemEn, b_MemWe});
        end
        n_cmp++;
        if ({b_MemAddr, b_MemWData, b_RData0, b_RData1} !== 104'b0) begin
            n_bad++;
            $display("FAIL reset_b_data: got addr=%h wdata=%h rd0=%h rd1=%h expected 0",
                     b_MemAddr, b_MemWData, b_RData0, b_RData1);
        end
        Req0  = 1'b0;
        Req1  = 1'b0;
        Reset = 1'b0;
    endtask

    task automatic test_single_load();
        int         req_edge, ack_c, en_cnt, st0;
        logic [7:0] en_addr;
        do_reset(1'b0);
        preload(1'b0, 8'h20, 32'hDEAD_BEEF);
        We0 = 1'b0; Addr0 = 32'h80; WData0 = 32'h0; Req0 = 1'b1;
        sbq.push_back('{lane: 1'b0, data: 32'hDEAD_BEEF});
        req_edge = cyc + 1; ack_c = -1; en_cnt = 0; st0 = 0; en_addr = 8'h0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            if (o_stall0) st0++;
            if (o_en) begin en_cnt++; en_addr = o_addr; end
            if (o_ack0 && ack_c < 0) begin ack_c = cyc; Req0 = 1'b0; end
        end
        n_cmp++;
        if (ack_c - req_edge != 2) begin
            n_bad++;
            $display("FAIL single_ack_latency: got %0d expected 2 (ack_cycle=%0d)", ack_c - req_edge, ack_c);
        end
        n_cmp++;
        if (en_cnt != 1) begin
            n_bad++;
            $display("FAIL single_memen_cycles: got %0d expected 1", en_cnt);
        end
        n_cmp++;
        if (en_addr !== 8'h20) begin
            n_bad++;
            $display("FAIL single_memaddr: got %h expected 20", en_addr);
        end
        n_cmp++;
        if (st0 != 2) begin
            n_bad++;
            $display("FAIL single_stall0_cycles: got %0d expected 2", st0);
        end
    endtask

    task automatic test_store_load_order();
        int req_edge, ack0_c, ack1_c;
        do_reset(1'b0);
        We0 = 1'b1; Addr0 = 32'h84; WData0 = 32'h11;       Req0 = 1'b1;
        We1 = 1'b0; Addr1 = 32'h84; WData1 = 32'hFFFF_FFFF; Req1 = 1'b1;
        sbq.push_back('{lane: 1'b0, data: 32'h0});
        sbq.push_back('{lane: 1'b1, data: 32'h11});
        req_edge = cyc + 1; ack0_c = -1; ack1_c = -1;
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            if (o_ack0 && ack0_c < 0) begin ack0_c = cyc; Req0 = 1'b0; end
            if (o_ack1 && ack1_c < 0) begin ack1_c = cyc; Req1 = 1'b0; end
        end
        n_cmp++;
        if (ack0_c - req_edge != 2) begin
            n_bad++;
            $display("FAIL order_ack0_latency: got %0d expected 2", ack0_c - req_edge);
        end
        n_cmp++;
        if (ack1_c < 0 || ack1_c - ack0_c != 2) begin
            n_bad++;
            $display("FAIL order_ack1_after_ack0: got ack0=%0d ack1=%0d expected ack1=ack0+2", ack0_c, ack1_c);
        end
    endtask

    task automatic test_lat3_load();
        int req_edge, ack_c, en_cnt, st1;
        do_reset(1'b1);
        preload(1'b1, 8'h10, 32'hCAFE_F00D);
        We1 = 1'b0; Addr1 = 32'h40; WData1 = 32'h0; Req1 = 1'b1;
        sbq.push_back('{lane: 1'b1, data: 32'hCAFE_F00D});
        req_edge = cyc + 1; ack_c = -1; en_cnt = 0; st1 = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            if (o_stall1) st1++;
            if (o_en) en_cnt++;
            if (o_ack1 && ack_c < 0) begin ack_c = cyc; Req1 = 1'b0; end
        end
        n_cmp++;
        if (ack_c - req_edge != 4) begin
            n_bad++;
            $display("FAIL lat3_ack_latency: got %0d expected 4", ack_c - req_edge);
        end
        n_cmp++;
        if (st1 != 4) begin
            n_bad++;
            $display("FAIL lat3_stall1_cycles: got %0d expected 4", st1);
        end
        n_cmp++;
        if (en_cnt != 1) begin
            n_bad++;
            $display("FAIL lat3_memen_cycles: got %0d expected 1", en_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int i0, i1, en_cnt, last_en, acks;
        do_reset(1'b0);
        i0 = 0; i1 = 0; en_cnt = 0; last_en = -1; acks = 0;
        We0 = 1'b1; Addr0 = 32'h100; WData0 = 32'hA000_0000; Req0 = 1'b1;
        We1 = 1'b0; Addr1 = 32'h100; WData1 = 32'h0;         Req1 = 1'b1;
        sbq.push_back('{lane: 1'b0, data: 32'h0});
        sbq.push_back('{lane: 1'b1, data: 32'hA000_0000});
        for (int c = 0; c < 30; c++) begin
            @(negedge CLK);
            if (o_en) begin
                if (last_en >= 0) begin
                    n_cmp++;
                    if (cyc - last_en != 2) begin
                        n_bad++;
                        $display("FAIL b2b_access_gap: got %0d expected 2 at cycle %0d", cyc - last_en, cyc);
                    end
                end
                last_en = cyc;
                en_cnt++;
            end
            if (o_ack0) begin
                acks++; i0++;
                if (i0 < 3) begin
                    Addr0  = 32'h100 + 32'(i0) * 32'd4;
                    WData0 = 32'hA000_0000 + 32'(i0);
                    sbq.push_back('{lane: 1'b0, data: 32'h0});
                end else begin
                    Req0 = 1'b0;
                end
            end
            if (o_ack1) begin
                acks++; i1++;
                if (i1 < 3) begin
                    Addr1 = 32'h100 + 32'(i1) * 32'd4;
                    sbq.push_back('{lane: 1'b1, data: 32'hA000_0000 + 32'(i1)});
                end else begin
                    Req1 = 1'b0;
                end
            end
        end
        n_cmp++;
        if (en_cnt != 6 || acks != 6) begin
            n_bad++;
            $display("FAIL b2b_counts: got memen=%0d acks=%0d expected 6 and 6", en_cnt, acks);
        end
    endtask

    task automatic test_reset_mid();
        int req_edge, ack_c, stray;
        do_reset(1'b1);
        preload(1'b1, 8'h11, 32'h1234_5678);
        preload(1'b1, 8'h12, 32'h9ABC_DEF0);
        We0 = 1'b0; Addr0 = 32'h44; WData0 = 32'h0; Req0 = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        Reset = 1'b1;
        Req0  = 1'b0;
        #1;
        n_cmp++;
        if ({o_en, o_ack0, o_ack1, o_addr} !== 11'b0) begin
            n_bad++;
            $display("FAIL midrst_outputs: got en=%b ack0=%b ack1=%b addr=%h expected all 0",
                     o_en, o_ack0, o_ack1, o_addr);
        end
        @(negedge CLK);
        Reset = 1'b0;
        stray = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            if (o_ack0 || o_ack1 || o_en) stray++;
        end
        n_cmp++;
        if (stray != 0) begin
            n_bad++;
            $display("FAIL midrst_abandoned: got %0d active cycles expected 0", stray);
        end
        Addr0 = 32'h48; Req0 = 1'b1;
        sbq.push_back('{lane: 1'b0, data: 32'h9ABC_DEF0});
        req_edge = cyc + 1; ack_c = -1;
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            if (o_ack0 && ack_c < 0) begin ack_c = cyc; Req0 = 1'b0; end
        end
        n_cmp++;
        if (ack_c - req_edge != 4) begin
            n_bad++;
            $display("FAIL midrst_new_latency: got %0d expected 4", ack_c - req_edge);
        end
    endtask

    initial begin
        Reset = 1'b1;
        Req0 = 1'b0; Req1 = 1'b0; We0 = 1'b0; We1 = 1'b0;
        Addr0 = '0; Addr1 = '0; WData0 = '0; WData1 = '0;
        pl_we = 1'b0; pl_sel = 1'b0; pl_addr = '0; pl_data = '0;
        sel = 1'b0;

        test_reset();
        mon_en = 1'b1;
        test_single_load();
        test_store_load_order();
        test_lat3_load();
        test_back_to_back();
        test_reset_mid();

        n_cmp++;
        if (sbq.size() != 0) begin
            n_bad++;
            $display("FAIL sb_leftover: got %0d unanswered expectations expected 0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
